qed_consistency_checker: RTL and testbench
==========================================

Name: qed_consistency_checker

Overview:
- Synthesisable, parametrised successor to the formal-only QED register consistency properties.
- Monitors a duplicated register file, split into an original half and a duplicate half, throughout an SQED run.
- Arms when the SIF commit pulses, then checks every enabled original/duplicate pair at each QED check point.
- Latches sticky diagnostics: first failing pair, both values, zero-register violations. Usable in simulation, emulation, or as a formal monitor.

Parameters:
- XLEN, 32, width of one architectural register.
- NREGS, 32, total registers on regs_flat; must be even and >=4. Pair i is register i versus register i+NREGS/2.
- CNT_W, 16, width of the saturating check counter.
- ZERO_CHECK, 1, when 1, registers 0 and NREGS/2 are checked for ==0 every cycle.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst, input, 1, synchronous active-high reset.
- sif_commit, input, 1, SIF commit level.
- sif_commit_pulsed, input, 1, single-cycle pulse at T_C; arms the checker.
- qed_check_valid, input, 1, QED check point; a check occurs when this and sif_commit are both high.
- clear, input, 1, synchronous clear of all sticky state; returns the FSM to IDLE.
- pair_mask, input, NREGS/2, per-pair enable. Bit 0 is ignored because pair 0 is covered by the zero check.
- regs_flat, input, NREGS*XLEN, register file; register k is at bits [k*XLEN +: XLEN].
- state, output, 2, FSM state: 0=IDLE, 1=ARMED, 2=FAILED.
- armed, output, 1, state==ARMED.
- check_fail, output, 1, sticky: a check point found an enabled pair mismatching.
- init_fail, output, 1, sticky: registers were not consistent when the checker armed.
- zero_fail, output, 1, sticky: register 0 or NREGS/2 was nonzero (only when ZERO_CHECK=1).
- error, output, 1, OR of check_fail, init_fail and zero_fail.
- fail_idx, output, clog2(NREGS/2), lowest failing pair index, captured on the first failure.
- fail_orig, output, XLEN, value of the original register at the first failure.
- fail_dup, output, XLEN, value of the duplicate register at the first failure.
- check_count, output, CNT_W, number of passing check points since arming; saturates at all-ones.

Behaviour:
- Reset values: every output is 0 after rst, and state=IDLE.
- Registered outputs: every output is registered, so a flag rises 1 cycle after the sampling edge.
- Mismatch vector: computed combinationally each cycle as mm[i] = pair_mask[i] && (reg[i] != reg[i+NREGS/2]) for i in 1..NREGS/2-1. mm[0] is always 0.
- Priority encoder: the lowest set bit of mm gives the failing index.
- IDLE, on sif_commit_pulsed:
  - mm==0: go to ARMED and zero check_count.
  - mm!=0: set init_fail, latch fail_idx/fail_orig/fail_dup, go to FAILED.
- IDLE, check point without a prior pulse: ignored.
- ARMED, check point (qed_check_valid && sif_commit):
  - mm==0: check_count increments, saturating.
  - mm!=0: set check_fail, latch the diagnostics, go to FAILED.
- ARMED, sif_commit_pulsed: re-arms. The initial-consistency rule is re-evaluated and check_count is zeroed. The pulse has priority over a check point in the same cycle.
- FAILED: sticky until clear or rst.
  - Diagnostics are never overwritten; only the first failure is kept.
  - Further pulses and check points are ignored.
- Zero check: evaluated every cycle in every state, independent of the FSM.
  - Sets zero_fail and does not change state.
  - Does not latch fail_* if an FSM failure has already captured them. Otherwise it latches fail_idx=0, fail_orig=reg0 and fail_dup=reg[NREGS/2], and these may still be overwritten by a later FSM failure.
- clear: takes effect the next cycle. It zeroes all sticky flags, diagnostics and check_count, and sets state=IDLE. clear beats any event in the same cycle; rst beats clear.
- Reset mid-run: any FSM state returns to IDLE, and armed must be 0 on the following cycle.
- pair_mask changes take effect on the very cycle they are sampled; there is no pipelining.

Test Plan:
- Arm then pass: rst, set regs[i]=regs[i+16]=i*3 for NREGS=32, pulse sif_commit_pulsed, then 3 check points -> state=1, check_count=3, error=0.
- Check mismatch: while ARMED, set reg5=0xDEAD, reg21=0xBEEF, reg9!=reg25, raise qed_check_valid&&sif_commit -> next cycle state=2, check_fail=1, fail_idx=5, fail_orig=0xDEAD, fail_dup=0xBEEF. A later check with reg3 mismatching leaves fail_idx=5.
- Initial inconsistency: reg7=1, reg23=2 at the pulse -> init_fail=1, state=2, fail_idx=7, check_count=0.
- Masking and zero check: pair_mask[4]=0 with reg4!=reg20 at a check -> no failure, count increments. Then reg16=1 -> zero_fail=1 with state unchanged at 1.
- Simultaneity and clear: pulse and check point in the same cycle while ARMED with count=5 -> count=0. Then clear and a mismatching check in the same cycle -> state=0, all flags 0.
- Saturation and reset: CNT_W=2, 5 passing checks -> check_count=3. Assert rst while FAILED -> all outputs 0 next cycle.

Source files
------------

// File: rtl/qed_consistency_checker.sv
// Register-file consistency monitor for SQED runs: compares each original/duplicate
// register pair at QED check points and keeps sticky first-failure diagnostics.
module qed_consistency_checker #(
    parameter int XLEN       = 32,
    parameter int NREGS      = 32,
    parameter int CNT_W      = 16,
    parameter bit ZERO_CHECK = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            sif_commit,
    input  logic                            sif_commit_pulsed,
    input  logic                            qed_check_valid,
    input  logic                            clear,
    input  logic [NREGS/2-1:0]              pair_mask,
    input  logic [NREGS*XLEN-1:0]           regs_flat,
    output logic [1:0]                      state,
    output logic                            armed,
    output logic                            check_fail,
    output logic                            init_fail,
    output logic                            zero_fail,
    output logic                            error,
    output logic [$clog2(NREGS/2)-1:0]      fail_idx,
    output logic [XLEN-1:0]                 fail_orig,
    output logic [XLEN-1:0]                 fail_dup,
    output logic [CNT_W-1:0]                check_count
);
    localparam int NP    = NREGS / 2;
    localparam int IDX_W = $clog2(NP);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_FAILED = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              armed_q;
    logic              check_fail_q, check_fail_d;
    logic              init_fail_q, init_fail_d;
    logic              zero_fail_q, zero_fail_d;
    logic              error_q, error_d;
    logic [IDX_W-1:0]  fail_idx_q, fail_idx_d;
    logic [XLEN-1:0]   fail_orig_q, fail_orig_d;
    logic [XLEN-1:0]   fail_dup_q, fail_dup_d;
    logic [CNT_W-1:0]  check_count_q, check_count_d;

    logic [XLEN-1:0]   orig_w [NP];
    logic [XLEN-1:0]   dup_w  [NP];
    logic [NP-1:0]     mm;
    logic              mm_any;
    logic [IDX_W-1:0]  first_idx;
    logic              zero_viol;
    logic              check_pt;
    logic              restart_ev, init_ev, check_ev, pass_ev;

    genvar gi;
    generate
        for (gi = 0; gi < NP; gi++) begin : g_pair
            assign orig_w[gi] = regs_flat[gi*XLEN +: XLEN];
            assign dup_w[gi]  = regs_flat[(gi+NP)*XLEN +: XLEN];
        end
        // Pair 0 is owned by the zero check, so its mask bit never contributes.
        assign mm[0] = pair_mask[0] & 1'b0;
        for (gi = 1; gi < NP; gi++) begin : g_mm
            assign mm[gi] = pair_mask[gi] && (orig_w[gi] != dup_w[gi]);
        end
    endgenerate

    assign mm_any    = |mm;
    assign zero_viol = ZERO_CHECK && ((orig_w[0] != '0) || (dup_w[0] != '0));
    assign check_pt  = qed_check_valid && sif_commit;

    always_comb begin
        first_idx = '0;
        for (int i = NP - 1; i >= 1; i--) begin
            if (mm[i]) first_idx = IDX_W'(i);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= (state_d == S_ARMED);
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = S_IDLE;
        end else if (init_ev || check_ev) begin
            state_d = S_FAILED;
        end else if (restart_ev) begin
            state_d = S_ARMED;
        end
    end

    // FSM event outputs; a pulse outranks a check point in the same cycle.
    always_comb begin
        restart_ev = 1'b0;
        init_ev    = 1'b0;
        check_ev   = 1'b0;
        pass_ev    = 1'b0;
        case (state_q)
            S_IDLE, S_ARMED: begin
                if (sif_commit_pulsed) begin
                    restart_ev = 1'b1;
                    init_ev    = mm_any;
                end else if (state_q == S_ARMED && check_pt) begin
                    check_ev = mm_any;
                    pass_ev  = !mm_any;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        check_fail_d  = check_fail_q | check_ev;
        init_fail_d   = init_fail_q | init_ev;
        zero_fail_d   = zero_fail_q | zero_viol;
        fail_idx_d    = fail_idx_q;
        fail_orig_d   = fail_orig_q;
        fail_dup_d    = fail_dup_q;
        check_count_d = check_count_q;

        if (restart_ev) begin
            check_count_d = '0;
        end else if (pass_ev && !(&check_count_q)) begin
            check_count_d = check_count_q + CNT_W'(1);
        end

        // An FSM failure always wins the diagnostics; a zero violation only fills them while empty.
        if (init_ev || check_ev) begin
            fail_idx_d  = first_idx;
            fail_orig_d = orig_w[first_idx];
            fail_dup_d  = dup_w[first_idx];
        end else if (zero_viol && !(zero_fail_q || check_fail_q || init_fail_q)) begin
            fail_idx_d  = '0;
            fail_orig_d = orig_w[0];
            fail_dup_d  = dup_w[0];
        end

        if (clear) begin
            check_fail_d  = 1'b0;
            init_fail_d   = 1'b0;
            zero_fail_d   = 1'b0;
            fail_idx_d    = '0;
            fail_orig_d   = '0;
            fail_dup_d    = '0;
            check_count_d = '0;
        end
        error_d = check_fail_d | init_fail_d | zero_fail_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            check_fail_q  <= 1'b0;
            init_fail_q   <= 1'b0;
            zero_fail_q   <= 1'b0;
            error_q       <= 1'b0;
            fail_idx_q    <= '0;
            fail_orig_q   <= '0;
            fail_dup_q    <= '0;
            check_count_q <= '0;
        end else begin
            check_fail_q  <= check_fail_d;
            init_fail_q   <= init_fail_d;
            zero_fail_q   <= zero_fail_d;
            error_q       <= error_d;
            fail_idx_q    <= fail_idx_d;
            fail_orig_q   <= fail_orig_d;
            fail_dup_q    <= fail_dup_d;
            check_count_q <= check_count_d;
        end
    end

    assign state       = state_q;
    assign armed       = armed_q;
    assign check_fail  = check_fail_q;
    assign init_fail   = init_fail_q;
    assign zero_fail   = zero_fail_q;
    assign error       = error_q;
    assign fail_idx    = fail_idx_q;
    assign fail_orig   = fail_orig_q;
    assign fail_dup    = fail_dup_q;
    assign check_count = check_count_q;

endmodule

// File: tb/tb_qed_consistency_checker.sv
// Scoreboard bench: the driver pushes the reference model's expected outputs per cycle,
// the monitor pops and compares them one cycle later.
module tb_qed_consistency_checker;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NP    = NREGS / 2;
    localparam int CNT_W = 3;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic                   clk = 1'b0;
    logic                   rst_r, pulse, cv, commit, clr;
    logic [NP-1:0]          mask;
    logic [XLEN-1:0]        regs [NREGS];
    logic [NREGS*XLEN-1:0]  regs_flat;

    logic [1:0]             d_state;
    logic                   d_armed, d_chk, d_ini, d_zro, d_err;
    logic [3:0]             d_idx;
    logic [XLEN-1:0]        d_orig, d_dup;
    logic [CNT_W-1:0]       d_cnt;

    typedef struct {
        logic [1:0]       st;
        logic             armed, chk, ini, zro, err;
        logic [3:0]       idx;
        logic [XLEN-1:0]  orig, dup;
        logic [CNT_W-1:0] cnt;
    } exp_t;
    exp_t exp_q [$];
    exp_t mon_e;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference state
    int              m_state;
    bit              m_chk, m_ini, m_zro;
    int              m_idx, m_cnt;
    logic [XLEN-1:0] m_orig, m_dup;

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < NREGS; k++) regs_flat[k*XLEN +: XLEN] = regs[k];
    end

    qed_consistency_checker #(
        .XLEN(XLEN), .NREGS(NREGS), .CNT_W(CNT_W), .ZERO_CHECK(1'b1)
    ) dut (
        .clk(clk), .rst(rst_r), .sif_commit(commit), .sif_commit_pulsed(pulse),
        .qed_check_valid(cv), .clear(clr), .pair_mask(mask), .regs_flat(regs_flat),
        .state(d_state), .armed(d_armed), .check_fail(d_chk), .init_fail(d_ini),
        .zero_fail(d_zro), .error(d_err), .fail_idx(d_idx), .fail_orig(d_orig),
        .fail_dup(d_dup), .check_count(d_cnt)
    );

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, expv);
        end
    endtask

    // Monitor: compare the DUT against the oldest expectation, one line per transaction
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("state", XLEN'(d_state), XLEN'(mon_e.st));
            chk("armed", XLEN'(d_armed), XLEN'(mon_e.armed));
            chk("check_fail", XLEN'(d_chk), XLEN'(mon_e.chk));
            chk("init_fail", XLEN'(d_ini), XLEN'(mon_e.ini));
            chk("zero_fail", XLEN'(d_zro), XLEN'(mon_e.zro));
            chk("error", XLEN'(d_err), XLEN'(mon_e.err));
            chk("fail_idx", XLEN'(d_idx), XLEN'(mon_e.idx));
            chk("fail_orig", d_orig, mon_e.orig);
            chk("fail_dup", d_dup, mon_e.dup);
            chk("check_count", XLEN'(d_cnt), XLEN'(mon_e.cnt));
            $display("cyc %0d state=%0d cnt=%0d err=%b idx=%0d", cyc, d_state, d_cnt, d_err, d_idx);
            cyc++;
        end
    end

    // Reference model: advances one clock from the current inputs, then pushes the expectation
    task automatic model();
        bit   any, cap, zv, old_any;
        int   first;
        exp_t e;
        any = 0;
        first = 0;
        for (int i = 1; i < NP; i++) begin
            if (!any && mask[i] && regs[i] != regs[i+NP]) begin
                any = 1;
                first = i;
            end
        end
        zv = (regs[0] != 0) || (regs[NP] != 0);
        if (rst_r || clr) begin
            m_state = 0; m_chk = 0; m_ini = 0; m_zro = 0;
            m_idx = 0; m_cnt = 0; m_orig = '0; m_dup = '0;
        end else begin
            cap = 0;
            old_any = m_chk || m_ini || m_zro;
            if (m_state != 2 && pulse) begin
                m_cnt = 0;
                if (any) begin m_ini = 1; m_state = 2; cap = 1; end
                else m_state = 1;
            end else if (m_state == 1 && cv && commit) begin
                if (any) begin m_chk = 1; m_state = 2; cap = 1; end
                else if (m_cnt < CMAX) m_cnt++;
            end
            if (cap) begin
                m_idx = first; m_orig = regs[first]; m_dup = regs[first+NP];
            end else if (zv && !old_any) begin
                m_idx = 0; m_orig = regs[0]; m_dup = regs[NP];
            end
            if (zv) m_zro = 1;
        end
        e.st = 2'(m_state); e.armed = (m_state == 1);
        e.chk = m_chk; e.ini = m_ini; e.zro = m_zro; e.err = m_chk | m_ini | m_zro;
        e.idx = 4'(m_idx); e.orig = m_orig; e.dup = m_dup; e.cnt = CNT_W'(m_cnt);
        exp_q.push_back(e);
    endtask

    task automatic tick(input bit p, input bit c, input bit cm, input bit cl, input bit r);
        pulse = p; cv = c; commit = cm; clr = cl; rst_r = r;
        model();
        @(negedge clk);
    endtask

    task automatic init_regs();
        for (int i = 0; i < NP; i++) begin
            regs[i] = XLEN'(i * 3);
            regs[i+NP] = XLEN'(i * 3);
        end
    endtask

    initial begin
        int r;
        mask = '1;
        init_regs();
        tick(0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 1);
        // Arm then pass
        tick(1, 0, 1, 0, 0);
        repeat (3) tick(0, 1, 1, 0, 0);
        tick(0, 0, 1, 0, 0);
        // Check mismatch, then a later mismatch must not overwrite the diagnostics
        regs[5] = 32'hDEAD; regs[21] = 32'hBEEF; regs[9] = 1; regs[25] = 2;
        tick(0, 1, 1, 0, 0);
        regs[3] = 7; regs[19] = 8;
        tick(0, 1, 1, 0, 0);
        tick(0, 0, 0, 1, 0);
        init_regs();
        // Initial inconsistency
        regs[7] = 1; regs[23] = 2;
        tick(1, 0, 1, 0, 0);
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 1, 0);
        init_regs();
        // Masking and zero check
        tick(1, 0, 1, 0, 0);
        mask[4] = 1'b0; regs[4] = 100; regs[20] = 200;
        tick(0, 1, 1, 0, 0);
        regs[16] = 1;
        tick(0, 0, 1, 0, 0);
        regs[16] = 0; mask = '1; init_regs();
        tick(0, 0, 0, 1, 0);
        // Simultaneity and clear
        tick(1, 0, 1, 0, 0);
        repeat (5) tick(0, 1, 1, 0, 0);
        tick(1, 1, 1, 0, 0);
        regs[2] = 55;
        tick(0, 1, 1, 1, 0);
        tick(0, 0, 0, 0, 0);
        init_regs();
        // Saturation, then reset while FAILED
        tick(1, 0, 1, 0, 0);
        repeat (9) tick(0, 1, 1, 0, 0);
        regs[2] = 5;
        tick(0, 1, 1, 0, 0);
        tick(0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 0);
        init_regs();
        // Randomized phase
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 99);
            if (r < 8) regs[$urandom_range(1, NREGS-1)] = $urandom;
            else if (r < 20) begin
                for (int k = 1; k < NP; k++) regs[k+NP] = regs[k];
                regs[0] = 0; regs[NP] = 0;
            end else if (r < 32) begin
                int k = $urandom_range(1, NP-1);
                regs[k+NP] = regs[k];
            end else if (r < 34) regs[0] = $urandom;
            else if (r < 44) begin regs[0] = 0; regs[NP] = 0; end
            mask = ($urandom_range(0, 3) == 0) ? NP'($urandom) : '1;
            tick($urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 99) == 0);
        end
        tick(0, 0, 0, 0, 0);
        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0 pending expectations", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
